// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and types for the FND scan controller.
//   SEG_CODE  - active-low 7-segment codes {dp,g,f,e,d,c,b,a} for digits 0..9, dp off
//   SEG_BLANK - all segments off
//   COM_DIG   - active-low digit enables for scan index 0..3
//   COM_OFF   - no digit enabled
//   conv_state_t - BCD conversion FSM states
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_CODE [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    localparam logic [3:0] COM_OFF = 4'b1111;
    localparam logic [3:0] COM_DIG [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    localparam logic [7:0] MAX_VAL = 8'd99;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    // Non-decimal nibbles map to blank rather than garbage segments.
    function automatic logic [7:0] seg_of(input logic [3:0] nib);
        logic [7:0] seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nib == 4'(i)) seg = SEG_CODE[i];
        end
        return seg;
    endfunction

    function automatic logic [7:0] clamp99(input logic [7:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// fnd_scan_ctrl_if: bundle between the counter blocks and the FND display stage.
//   value_hi/value_lo - binary 0..99 pair values (left/right)
//   dp_en             - separator decimal point on digit 2
//   blink_en/blink_sel- blanking-blink enable and pair select (bit0 lo, bit1 hi)
//   seg_7/com         - active-low segment and digit-enable outputs
// master: the counter side driving values; slave: the display controller.
interface fnd_scan_ctrl_if;
    logic [7:0] value_hi;
    logic [7:0] value_lo;
    logic       dp_en;
    logic       blink_en;
    logic [1:0] blink_sel;
    logic [7:0] seg_7;
    logic [3:0] com;

    modport master (
        output value_hi, value_lo, dp_en, blink_en, blink_sel,
        input  seg_7, com
    );

    modport slave (
        input  value_hi, value_lo, dp_en, blink_en, blink_sel,
        output seg_7, com
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble datapath, 8-bit binary (0..99) to two BCD nibbles.
//   clk, reset_p - clock, synchronous active-high reset
//   load         - capture bin into the shift register and clear the accumulator
//   shift        - one adjust-and-shift step; 8 steps give the result
//   bin          - binary input
//   bcd          - {tens, ones} accumulator, valid after the 8th shift
module bin_to_bcd_seq (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] bin,
    output logic [7:0] bcd
);
    logic [7:0]  sh_q;
    logic [7:0]  acc_q;
    logic [7:0]  acc_adj;
    logic [15:0] shifted;

    always_comb begin
        acc_adj = acc_q;
        if (acc_q[3:0] >= 4'd5) acc_adj[3:0] = acc_q[3:0] + 4'd3;
        if (acc_q[7:4] >= 4'd5) acc_adj[7:4] = acc_q[7:4] + 4'd3;
        shifted = {acc_adj, sh_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            sh_q  <= '0;
            acc_q <= '0;
        end else if (load) begin
            sh_q  <= bin;
            acc_q <= '0;
        end else if (shift) begin
            acc_q <= shifted[15:8];
            sh_q  <= shifted[7:0];
        end
    end

    assign bcd = acc_q;
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: converts two 0..99 values to BCD once per scan frame and multiplexes the
// four digits onto a common-anode 7-segment display with dp separator and pair blinking.
//   clk, reset_p - clock, synchronous active-high reset
//   bus (slave)  - value_hi/value_lo/dp_en/blink_en/blink_sel in, seg_7/com out
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1_000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic             clk,
    input  logic             reset_p,
    fnd_scan_ctrl_if.slave   bus
);
    localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  presc_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;
    logic [1:0]         idx_q;
    logic               scan_tick;
    logic               blink_wrap;
    logic               frame_start;

    assign scan_tick   = (presc_q == SCAN_W'(SCAN_DIV - 1));
    assign blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    // Index 3 rolling over to 0 marks the start of a new frame.
    assign frame_start = scan_tick && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            presc_q       <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_q     <= scan_tick ? '0 : presc_q + SCAN_W'(1);
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
            if (scan_tick)  idx_q         <= idx_q + 2'd1;
            if (blink_wrap) blink_phase_q <= ~blink_phase_q;
        end
    end

    // Conversion FSM: both converters run in lock-step so both pairs update together.
    conv_state_t state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  samp_hi_q, samp_lo_q;
    logic [7:0]  disp_hi_q, disp_lo_q;
    logic        load_q, shift_q;
    logic [7:0]  bcd_hi, bcd_lo;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            samp_hi_q <= '0;
            samp_lo_q <= '0;
            disp_hi_q <= '0;
            disp_lo_q <= '0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        samp_hi_q <= clamp99(bus.value_hi);
                        samp_lo_q <= clamp99(bus.value_lo);
                        load_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    load_q    <= 1'b0;
                    shift_q   <= 1'b1;
                    bit_cnt_q <= '0;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        shift_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_hi_q <= bcd_hi;
                    disp_lo_q <= bcd_lo;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bin_to_bcd_seq u_conv_hi (
        .clk     (clk),
        .reset_p (reset_p),
        .load    (load_q),
        .shift   (shift_q),
        .bin     (samp_hi_q),
        .bcd     (bcd_hi)
    );

    bin_to_bcd_seq u_conv_lo (
        .clk     (clk),
        .reset_p (reset_p),
        .load    (load_q),
        .shift   (shift_q),
        .bin     (samp_lo_q),
        .bcd     (bcd_lo)
    );

    // Output stage: digit select, dp, blanking, then register.
    logic [3:0] nib;
    logic       blank;
    logic [7:0] seg_d, seg_q;
    logic [3:0] com_d, com_q;

    always_comb begin
        unique case (idx_q)
            2'd0:    nib = disp_lo_q[3:0];
            2'd1:    nib = disp_lo_q[7:4];
            2'd2:    nib = disp_hi_q[3:0];
            default: nib = disp_hi_q[7:4];
        endcase
        // idx_q[1] distinguishes the hi pair (digits 2,3) from the lo pair (digits 0,1).
        blank = bus.blink_en && blink_phase_q &&
                (idx_q[1] ? bus.blink_sel[1] : bus.blink_sel[0]);
        seg_d = seg_of(nib);
        if (idx_q == 2'd2 && bus.dp_en) seg_d[7] = 1'b0;
        com_d = COM_DIG[idx_q];
        if (blank) begin
            seg_d = SEG_BLANK;
            com_d = COM_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            seg_q <= SEG_BLANK;
            com_q <= COM_OFF;
        end else begin
            seg_q <= seg_d;
            com_q <= com_d;
        end
    end

    assign bus.seg_7 = seg_q;
    assign bus.com   = com_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed, table-driven bench for fnd_scan_ctrl with a 10-cycle scan tick
// and a 20-cycle blink half-period. Timing expectations are tied to cyc, the number of clock
// edges since the last reset edge: a frame start is the cycle where cyc % 40 == 39.
module tb_fnd_scan_ctrl;
    import fnd_pkg::*;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned SCAN_HZ  = 100;
    localparam int unsigned BLINK_HZ = 25;

    logic clk     = 1'b0;
    logic reset_p = 1'b1;

    fnd_scan_ctrl_if bus ();

    fnd_scan_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) u_dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0]      hi;
        logic [7:0]      lo;
        logic            dp;
        logic [3:0][7:0] seg;  // {idx3, idx2, idx1, idx0}
    } vec_t;

    vec_t vecs [6];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    // Advance to the next frame-start cycle (always at least one edge).
    task automatic goto_fs();
        tick(1);
        while (cyc % 40 != 39) tick(1);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] com, input logic [7:0] seg);
        check(name, {4'h0, bus.com, bus.seg_7}, {4'h0, com, seg});
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    logic [7:0] prev_lo;
    logic [3:0] exp_com;
    logic [7:0] exp_seg;
    logic [7:0] blink_segs [4];
    logic [3:0] com_pat [4];

    initial begin
        com_pat[0] = 4'b1110; com_pat[1] = 4'b1101; com_pat[2] = 4'b1011; com_pat[3] = 4'b0111;

        vecs[0] = '{hi: 8'd12,  lo: 8'd34,  dp: 1'b1, seg: {8'hF9, 8'h24, 8'hB0, 8'h99}};
        vecs[1] = '{hi: 8'd0,   lo: 8'd0,   dp: 1'b0, seg: {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[2] = '{hi: 8'd255, lo: 8'd200, dp: 1'b0, seg: {8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[3] = '{hi: 8'd5,   lo: 8'd7,   dp: 1'b1, seg: {8'hC0, 8'h12, 8'hC0, 8'hF8}};
        vecs[4] = '{hi: 8'd86,  lo: 8'd13,  dp: 1'b0, seg: {8'h80, 8'h82, 8'hF9, 8'hB0}};
        vecs[5] = '{hi: 8'd100, lo: 8'd99,  dp: 1'b1, seg: {8'h90, 8'h10, 8'h90, 8'h90}};

        bus.value_hi  = 8'd0;
        bus.value_lo  = 8'd0;
        bus.dp_en     = 1'b0;
        bus.blink_en  = 1'b0;
        bus.blink_sel = 2'b00;

        // Reset state.
        reset_p = 1'b1;
        tick(2);
        cyc = 0;
        check_out("reset_out", 4'b1111, 8'hFF);
        check("reset_state", 16'(u_dut.state_q), 16'(IDLE));
        reset_p = 1'b0;
        tick(1);
        check_out("first_digit", 4'b1110, 8'hC0);

        // Static display vectors, observed on the frame after conversion.
        for (int v = 0; v < 6; v++) begin
            bus.value_hi = vecs[v].hi;
            bus.value_lo = vecs[v].lo;
            bus.dp_en    = vecs[v].dp;
            goto_fs();
            goto_fs();
            for (int k = 0; k < 4; k++) begin
                tick(k == 0 ? 5 : 10);
                check_out($sformatf("vec%0d_idx%0d", v, k), com_pat[k], vecs[v].seg[k]);
            end
        end

        // Full lo sweep with exact update latency.
        prev_lo = 8'h99;
        for (int v = 0; v < 100; v++) begin
            bus.value_lo = 8'(v);
            goto_fs();
            tick(10);
            check($sformatf("sweep_early_%0d", v), 16'(u_dut.disp_lo_q), 16'(prev_lo));
            tick(1);
            check($sformatf("sweep_%0d", v), 16'(u_dut.disp_lo_q), 16'(bcd(v)));
            prev_lo = bcd(v);
        end

        // Mid-frame change stays hidden until the next frame start.
        bus.value_hi = 8'd59;
        bus.value_lo = 8'd0;
        bus.dp_en    = 1'b0;
        goto_fs();
        goto_fs();
        tick(1);
        bus.value_hi = 8'd60;
        tick(24);
        check_out("midframe_idx2_old", 4'b1011, 8'h90);
        tick(10);
        check_out("midframe_idx3_old", 4'b0111, 8'h92);
        goto_fs();
        tick(25);
        check_out("midframe_idx2_new", 4'b1011, 8'hC0);
        tick(10);
        check_out("midframe_idx3_new", 4'b0111, 8'h82);

        // Blink: displayed 45 78; expected blanking follows the edge-count model.
        bus.value_hi = 8'd45;
        bus.value_lo = 8'd78;
        goto_fs();
        goto_fs();
        tick(12);
        blink_segs[0] = 8'h80; blink_segs[1] = 8'hF8; blink_segs[2] = 8'h92; blink_segs[3] = 8'h99;
        for (int c = 0; c < 4; c++) begin
            bus.blink_en  = (c != 3);
            bus.blink_sel = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : (c == 2) ? 2'b00 : 2'b11;
            for (int n = 0; n < 80; n++) begin
                int i;
                int ph;
                tick(1);
                i  = ((cyc - 1) / 10) % 4;
                ph = ((cyc - 1) / 20) % 2;
                exp_com = com_pat[i];
                exp_seg = blink_segs[i];
                if (bus.blink_en && ph == 1 && bus.blink_sel[i / 2]) begin
                    exp_com = 4'b1111;
                    exp_seg = 8'hFF;
                end
                check($sformatf("blink%0d_n%0d", c, n), {4'h0, bus.com, bus.seg_7},
                      {4'h0, exp_com, exp_seg});
            end
        end
        bus.blink_en  = 1'b0;
        bus.blink_sel = 2'b00;

        // Reset during SHIFT discards the partial result.
        bus.value_hi = 8'd23;
        bus.value_lo = 8'd47;
        bus.dp_en    = 1'b1;
        goto_fs();
        tick(4);
        check("in_shift", 16'(u_dut.state_q), 16'(SHIFT));
        reset_p = 1'b1;
        tick(1);
        cyc = 0;
        reset_p = 1'b0;
        check_out("rst_mid_out", 4'b1111, 8'hFF);
        check("rst_mid_state", 16'(u_dut.state_q), 16'(IDLE));
        check("rst_mid_disp", 16'(u_dut.disp_lo_q), 16'h0000);
        bus.value_hi = 8'd62;
        bus.value_lo = 8'd81;
        tick(5);
        check_out("rst_zero_idx0", 4'b1110, 8'hC0);
        tick(10);
        check_out("rst_zero_idx1", 4'b1101, 8'hC0);
        tick(10);
        check_out("rst_zero_idx2", 4'b1011, 8'h40);
        tick(10);
        check_out("rst_zero_idx3", 4'b0111, 8'hC0);
        goto_fs();
        tick(10);
        check("rst_conv_early", 16'(u_dut.disp_lo_q), 16'h0000);
        tick(1);
        check("rst_conv_lo", 16'(u_dut.disp_lo_q), 16'h0081);
        check("rst_conv_hi", 16'(u_dut.disp_hi_q), 16'h0062);
        tick(1);
        check_out("rst_conv_idx1", 4'b1101, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
